// File: rtl/nn_frame_streamer_if.sv
// Upstream AXI4-Stream beat bundle feeding the frame streamer.
// Producer drives data/valid/last, the streamer answers with ready.
interface nn_frame_streamer_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tdata, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/nn_frame_streamer.sv
// Ping-pong frame buffer replaying whole frames to the classifier input.
// Optional hold for the prediction and a minimum idle gap between bursts.
module nn_frame_streamer #(
   parameter int DATA_WIDTH  = 8,
   parameter int FRAME_LEN   = 720,
   parameter int WAIT_RESULT = 1,
   parameter int GAP_CYCLES  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   nn_frame_streamer_if.slave    s,
   output logic [DATA_WIDTH-1:0] axi_in_tdata,
   output logic                  axi_in_tvalid,
   output logic                  axi_in_tlast,
   input  logic                  result_valid,
   output logic                  frame_err,
   output logic [15:0]           frames_sent,
   output logic                  busy
);
   localparam int CW = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
   localparam logic [GW-1:0] GLAST =
      GW'((GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, GAP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic [CW-1:0]         rcnt_q, rcnt_d;
   logic                  wbank_q, wbank_d;
   logic                  rbank_q, rbank_d;
   logic [1:0]            full_q, full_d;
   logic                  disc_q, disc_d;
   logic                  err_q, err_d;
   logic [GW-1:0]         gcnt_q, gcnt_d;
   logic                  vld_q, last_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [15:0]           sent_q;

   logic [DATA_WIDTH-1:0] mem [2][FRAME_LEN];

   logic       acc, wr_en, rd_last;
   logic [1:0] set_full, clr_full;

   assign s.tready = !rst && (disc_q || !full_q[wbank_q]);
   assign acc      = s.tvalid && s.tready;
   assign rd_last  = (state_q == STREAM) && (rcnt_q == LAST);
   assign full_d   = (full_q | set_full) & ~clr_full;

   always_comb begin
      wcnt_d   = wcnt_q;
      wbank_d  = wbank_q;
      disc_d   = disc_q;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      set_full = 2'b00;
      if (acc) begin
         priority case (1'b1)
            disc_q: disc_d = !s.tlast;
            (wcnt_q == LAST) && s.tlast: begin
               wr_en             = 1'b1;
               set_full[wbank_q] = 1'b1;
               wbank_d           = !wbank_q;
               wcnt_d            = '0;
            end
            // overlong frame: drop the rest up to its tlast
            (wcnt_q == LAST): begin
               wr_en  = 1'b1;
               err_d  = 1'b1;
               disc_d = 1'b1;
               wcnt_d = '0;
            end
            s.tlast: begin
               wr_en  = 1'b1;
               err_d  = 1'b1;
               wcnt_d = '0;
            end
            default: begin
               wr_en  = 1'b1;
               wcnt_d = wcnt_q + 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      rbank_d  = rbank_q;
      gcnt_d   = gcnt_q;
      clr_full = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (full_q[rbank_q]) begin
               state_d = STREAM;
               rcnt_d  = '0;
            end
         end
         STREAM: begin
            if (rcnt_q == LAST) begin
               clr_full[rbank_q] = 1'b1;
               rbank_d           = !rbank_q;
               rcnt_d            = '0;
               gcnt_d            = '0;
               if (WAIT_RESULT != 0)
                  state_d = WAIT_RES;
               else if (GAP_CYCLES > 0)
                  state_d = GAP;
               else if (full_q[!rbank_q])
                  state_d = STREAM;
               else
                  state_d = IDLE;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         WAIT_RES: begin
            if (result_valid) begin
               gcnt_d  = '0;
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            // IDLE adds one more quiet cycle before the next burst
            if ((GAP_CYCLES <= 1) || (gcnt_q == GLAST))
               state_d = IDLE;
            else
               gcnt_d = gcnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         full_q  <= 2'b00;
         disc_q  <= 1'b0;
         err_q   <= 1'b0;
         gcnt_q  <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         full_q  <= full_d;
         disc_q  <= disc_d;
         err_q   <= err_d;
         gcnt_q  <= gcnt_d;
         vld_q   <= (state_q == STREAM);
         last_q  <= rd_last;
         if (state_q == STREAM)
            data_q <= mem[rbank_q][rcnt_q];
         sent_q  <= sent_q + 16'(rd_last);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wbank_q][wcnt_q] <= s.tdata;
   end

   assign axi_in_tdata  = data_q;
   assign axi_in_tvalid = vld_q;
   assign axi_in_tlast  = last_q;
   assign frame_err     = err_q;
   assign frames_sent   = sent_q;
   assign busy          = (state_q != IDLE) || (|full_q);
endmodule

// File: doc/nn_frame_streamer.md
# nn_frame_streamer

Frame source for the classifier input stream. Accepts feature frames from an upstream AXI4-Stream producer with backpressure and stores them in a two-bank ping-pong buffer. Replays each complete frame to the classifier's backpressure-free input port (`axi_in_tdata/tvalid/tlast`) as one unbroken burst. It optionally holds the next frame until the classifier reports a prediction.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of a feature sample
- `FRAME_LEN`, 720, samples per frame; must be ≥2
- `WAIT_RESULT`, 1, 1 = after a frame, hold until `result_valid`; 0 = do not wait
- `GAP_CYCLES`, 0, minimum idle cycles inserted after each frame (after any result wait)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `s_tdata`  in  DATA_WIDTH  upstream sample
- `s_tvalid`  in  1  upstream beat valid
- `s_tlast`  in  1  upstream end-of-frame marker
- `s_tready`  out  1  beat accepted when `s_tvalid && s_tready`
- `axi_in_tdata`  out  DATA_WIDTH  sample to classifier
- `axi_in_tvalid`  out  1  sample valid; the classifier cannot stall
- `axi_in_tlast`  out  1  high on sample `FRAME_LEN-1` of each burst
- `result_valid`  in  1  classifier `predictions_valid`
- `frame_err`  out  1  one-cycle pulse, malformed upstream frame dropped
- `frames_sent`  out  16  count of completed bursts; wraps modulo 2^16
- `busy`  out  1  FSM not IDLE, or either bank full

## Operation
- **Storage:** 2×`FRAME_LEN` words with synchronous read. Each bank has a `bank_full` flag. The write pointer is `wcnt`/`wbank`; the read pointer is `rcnt`/`rbank`. Both banks start at 0.
- **Ready:** `s_tready = !rst && (discard || !bank_full[wbank])`.
- **Normal write:** an accepted beat writes `mem[wbank][wcnt]`.
  - With `wcnt<FRAME_LEN-1` and `s_tlast=0`, `wcnt` increments.
  - With `wcnt==FRAME_LEN-1` and `s_tlast=1`, the bank commits: `bank_full[wbank]` is set, `wbank` toggles and `wcnt` returns to 0.
- **Short frame:** `s_tlast=1` with `wcnt<FRAME_LEN-1` pulses `frame_err`, sets `wcnt` to 0 and leaves the bank uncommitted.
- **Long frame:** `s_tlast=0` with `wcnt==FRAME_LEN-1` pulses `frame_err`, sets `wcnt` to 0 and enters discard mode. In discard mode, beats are accepted and dropped up to and including the next `s_tlast=1` beat. No error pulse is raised for the discarded beats.
- **Read FSM states:** IDLE, STREAM, WAIT_RES, GAP.
- **IDLE:**
  - If `bank_full[rbank]`, go to STREAM with `rcnt=0`.
- **STREAM:**
  - Each cycle issues a read of `mem[rbank][rcnt]`. The output register delivers the data one cycle later, with `axi_in_tvalid=1` and `axi_in_tlast=(rcnt==FRAME_LEN-1)` delayed by the same cycle.
  - On `rcnt==FRAME_LEN-1`: clear `bank_full[rbank]`, toggle `rbank`, then take the next state below.
  - Go to WAIT_RES if `WAIT_RESULT=1`.
  - Otherwise go to GAP if `GAP_CYCLES>0`.
  - Otherwise, if the other bank is already full, stay in STREAM with `rcnt=0`. This gives back-to-back bursts with no idle cycle.
  - Otherwise go to IDLE.
- **WAIT_RES:**
  - On `result_valid=1`, go to GAP if `GAP_CYCLES>0`, else to IDLE.
  - `result_valid` is ignored in every other state.
- **GAP:** counts `GAP_CYCLES` cycles, then goes to IDLE.
- **frames_sent:** increments on the edge that registers the `axi_in_tlast` beat.
- **Simultaneous events:**
  - A bank release and a write to the other bank in the same cycle are both honored.
  - A bank released on cycle N is writable (`s_tready=1` if it is `wbank`) on cycle N+1.

## Timing
- **Reset:** when `rst` is high at an edge, all state returns to its initial value.
  - All outputs are 0: `axi_in_tdata`, `axi_in_tvalid`, `axi_in_tlast`, `frame_err`, `frames_sent`, `busy`.
  - `s_tready` is 0 while `rst` is high.
  - Both banks are emptied, discard mode is cleared and the FSM is in IDLE.
  - Reset mid-burst truncates the burst immediately, with no `tlast` emitted.
- **Latency:** if the committing beat is accepted at edge E, `axi_in_tvalid` first rises after edge E+2. The stream then stays high for exactly `FRAME_LEN` consecutive cycles.
- **Throughput:**
  - Upstream: one beat per cycle while a bank is free.
  - Downstream: one sample per cycle within a burst; `axi_in_tvalid` never drops mid-burst.
- **Error pulse:** `frame_err` is high for the single cycle after the offending beat's edge.

## Test plan
- **Single frame:** `FRAME_LEN=8`, `WAIT_RESULT=0`. Send 0x01..0x08 with `tlast` on 0x08 → `axi_in_tvalid` high 8 cycles starting E+2, data 0x01..0x08, `tlast` only on 0x08, `frames_sent=1`.
- **Ping-pong fill:** `WAIT_RESULT=1`. Send 3 frames with no `result_valid` → frame 1 streams; frames 2–3 fill the banks; `s_tready` drops after frame 3; a `result_valid` pulse → frame 2 streams with no gap in data.
- **Back-to-back:** `WAIT_RESULT=0`, `GAP_CYCLES=0`, two banks full → 16 consecutive valid cycles, `tlast` at beats 8 and 16.
- **Short and long frames:** a short frame (5 beats, `tlast` on beat 5) → `frame_err` pulse, nothing streamed. A long frame (12 beats, `tlast` on beat 12) → one pulse, beats 9–12 dropped. A following good frame streams correctly.
- **Gap:** `GAP_CYCLES=3`, `WAIT_RESULT=0`, two frames queued → exactly 3 idle cycles between bursts.
- **Reset mid-burst:** assert `rst` at beat 4 → next cycle all outputs 0, `s_tready=0`. After release, `s_tready=1`, `frames_sent=0`, and a new frame streams normally.
